// File: rtl/gb_cpu_common_pkg.sv
// Shared Game Boy CPU constants: M-cycle geometry and the CB prefix byte.
package gb_cpu_common_pkg;

    // T-cycles per M-cycle and deepest schedule the decoder may return.
    localparam int unsigned M_CYCLE_T_LEN = 4;
    localparam int unsigned MAX_M_CYCLES  = 6;

    // Opcode that selects the CB instruction table for the following byte.
    localparam logic [7:0] CB_PREFIX_OPCODE = 8'hCB;

    // Index of the final T-cycle inside an M-cycle.
    localparam logic [1:0] T_LAST = 2'(M_CYCLE_T_LEN - 1);

endpackage : gb_cpu_common_pkg

// File: rtl/gb_cpu_decoder_pkg.sv
// Decoder-facing types: per-M-cycle control word and the instruction schedule.
package gb_cpu_decoder_pkg;

    import gb_cpu_common_pkg::*;

    // Address bus source for the M-cycle.
    typedef enum logic [1:0] {
        ADDR_PC  = 2'd0,
        ADDR_SP  = 2'd1,
        ADDR_HL  = 2'd2,
        ADDR_TMP = 2'd3
    } addr_sel_e;

    // Control word driven to the datapath for one M-cycle.
    typedef struct packed {
        addr_sel_e   addr_sel;
        logic        mem_rd;
        logic        mem_wr;
        logic        pc_inc;
        logic [3:0]  alu_op;
        logic [2:0]  src_sel;
        logic [2:0]  dst_sel;
        logic        ld_en;
    } control_t;

    // Opcode fetch only: read (PC), increment PC, no register side effects.
    localparam control_t FETCH_ONLY_CTRL = '{
        addr_sel: ADDR_PC,
        mem_rd:   1'b1,
        mem_wr:   1'b0,
        pc_inc:   1'b1,
        alu_op:   4'd0,
        src_sel:  3'd0,
        dst_sel:  3'd0,
        ld_en:    1'b0
    };

    // Full M-cycle schedule for one opcode, as returned by the decoder.
    typedef struct packed {
        logic [2:0]                          num_cycles;
        control_t [0:MAX_M_CYCLES-1]         cycles;
        logic                                cond_check;
        logic [2:0]                          cond_cycle;
    } schedule_t;

    // Clamp a raw cycle count into 1..MAX_M_CYCLES (0 is treated as 1).
    function automatic logic [2:0] eff_num_cycles(input logic [2:0] n);
        logic [2:0] r;
        if (n == 3'd0) begin
            r = 3'd1;
        end else if (n > 3'(MAX_M_CYCLES)) begin
            r = 3'(MAX_M_CYCLES);
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage : gb_cpu_decoder_pkg

// File: rtl/gb_cpu_tcycle_counter.sv
// Free-running 2-bit T-cycle counter with a strobe on the last T-cycle.
module gb_cpu_tcycle_counter
    import gb_cpu_common_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] t_cycle_o,
    output logic       t3_o
);

    logic [1:0] t_q;
    logic [1:0] t_d;

    // Next T-cycle: natural 2-bit wrap 3 -> 0.
    always_comb begin
        t_d = t_q + 2'd1;
    end

    // T-cycle register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= 2'd0;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_cycle_o = t_q;
    assign t3_o      = (t_q == T_LAST);

endmodule : gb_cpu_tcycle_counter

// File: rtl/gb_cpu_sequencer.sv
// Game Boy CPU M-cycle sequencer: owns IR and the CB flag, walks the decoder
// schedule one M-cycle at a time, and overlaps the next opcode fetch with the
// last M-cycle of each instruction.
module gb_cpu_sequencer
    import gb_cpu_common_pkg::*;
    import gb_cpu_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  schedule_t  schedule,
    input  logic       cond_true,
    input  logic [7:0] data_in,
    output logic [7:0] opcode,
    output logic       cb_prefix,
    output control_t   ctrl,
    output logic [2:0] m_cycle,
    output logic [1:0] t_cycle,
    output logic       instr_done
);

    // Registered sequencer state.
    logic [7:0] ir_q,        ir_d;
    logic       cb_q,        cb_d;
    logic [2:0] m_q,         m_d;
    logic       cond_fail_q, cond_fail_d;

    // Derived per-M-cycle status.
    logic       t3_s;
    logic       prefix_pending_s;
    logic       last_s;
    logic       cond_hit_s;
    logic [2:0] num_eff_s;
    control_t   ctrl_s;

    gb_cpu_tcycle_counter u_tcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .t_cycle_o (t_cycle),
        .t3_o      (t3_s)
    );

    // Classify the current M-cycle: prefix fetch, last cycle, condition probe.
    always_comb begin
        num_eff_s        = eff_num_cycles(schedule.num_cycles);
        prefix_pending_s = (ir_q == CB_PREFIX_OPCODE) && !cb_q && (m_q == 3'd0);
        last_s           = (m_q == (num_eff_s - 3'd1)) || cond_fail_q || prefix_pending_s;
        cond_hit_s       = schedule.cond_check && (m_q == schedule.cond_cycle) && !cond_true;
    end

    // Select the control word; a failed condition or prefix byte only fetches.
    always_comb begin
        if (cond_fail_q || prefix_pending_s) begin
            ctrl_s = FETCH_ONLY_CTRL;
        end else if (m_q < 3'(MAX_M_CYCLES)) begin
            ctrl_s = schedule.cycles[m_q];
        end else begin
            ctrl_s = FETCH_ONLY_CTRL;
        end
    end

    // Next-state: advance at T3; on the last M-cycle load IR from the bus.
    always_comb begin
        ir_d        = ir_q;
        cb_d        = cb_q;
        m_d         = m_q;
        cond_fail_d = cond_fail_q;
        if (t3_s) begin
            if (last_s) begin
                ir_d        = data_in;
                m_d         = 3'd0;
                cond_fail_d = 1'b0;
                // Prefix byte arms the CB table; otherwise the CB instruction ends.
                cb_d        = prefix_pending_s;
            end else begin
                m_d = m_q + 3'd1;
                if (cond_hit_s) begin
                    cond_fail_d = 1'b1;
                end else begin
                    cond_fail_d = cond_fail_q;
                end
            end
        end else begin
            m_d = m_q;
        end
    end

    // Sequencer state registers, all returning to the implicit NOP on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q        <= 8'h00;
            cb_q        <= 1'b0;
            m_q         <= 3'd0;
            cond_fail_q <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            cb_q        <= cb_d;
            m_q         <= m_d;
            cond_fail_q <= cond_fail_d;
        end
    end

    assign opcode     = ir_q;
    assign cb_prefix  = cb_q;
    assign m_cycle    = m_q;
    assign ctrl       = ctrl_s;
    // The prefix fetch is not the end of an instruction, so it does not pulse.
    assign instr_done = t3_s && last_s && !prefix_pending_s;

endmodule : gb_cpu_sequencer

// File: tb/tb_gb_cpu_sequencer.sv
// Self-checking bench for gb_cpu_sequencer: a small decoder table feeds the
// schedule, expected per-clk output tuples are queued when an instruction is
// started and compared on each falling edge.
module tb_gb_cpu_sequencer;

    import gb_cpu_common_pkg::*;
    import gb_cpu_decoder_pkg::*;

    logic       clk;
    logic       rst_n;
    schedule_t  schedule_s;
    logic       cond_true_s;
    logic [7:0] data_in_s;
    logic [7:0] opcode_s;
    logic       cb_prefix_s;
    control_t   ctrl_s;
    logic [2:0] m_cycle_s;
    logic [1:0] t_cycle_s;
    logic       instr_done_s;

    int n_cmp;
    int n_err;

    logic [30:0] exp_q[$];
    logic [7:0]  cur_op;
    logic        cur_cb;

    gb_cpu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .schedule   (schedule_s),
        .cond_true  (cond_true_s),
        .data_in    (data_in_s),
        .opcode     (opcode_s),
        .cb_prefix  (cb_prefix_s),
        .ctrl       (ctrl_s),
        .m_cycle    (m_cycle_s),
        .t_cycle    (t_cycle_s),
        .instr_done (instr_done_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distinct, recognisable control word per table slot (never FETCH_ONLY).
    function automatic control_t mk(input int i);
        return control_t'(16'h8000 | 16'(i));
    endfunction

    // Bench decoder table.
    function automatic schedule_t decode(input logic [7:0] op, input logic cb);
        schedule_t s;
        s = '0;
        if (cb) begin
            case (op)
                8'h37: begin s.num_cycles = 3'd1; s.cycles[0] = mk(20); end
                8'hCB: begin s.num_cycles = 3'd2; s.cycles[0] = mk(21); s.cycles[1] = mk(22); end
                default: begin s.num_cycles = 3'd1; s.cycles[0] = mk(23); end
            endcase
        end else begin
            case (op)
                8'h00: begin s.num_cycles = 3'd1; s.cycles[0] = mk(1); end
                8'h80: begin s.num_cycles = 3'd1; s.cycles[0] = mk(2); end
                8'h20: begin
                    s.num_cycles = 3'd3; s.cond_check = 1'b1; s.cond_cycle = 3'd0;
                    s.cycles[0] = mk(3); s.cycles[1] = mk(4); s.cycles[2] = mk(5);
                end
                8'h10: begin s.num_cycles = 3'd0; s.cycles[0] = mk(6); end
                8'hCB: begin s.num_cycles = 3'd1; s.cycles[0] = mk(7); end
                8'hC2: begin
                    s.num_cycles = 3'd5; s.cond_check = 1'b1; s.cond_cycle = 3'd1;
                    for (int i = 0; i < 5; i++) s.cycles[i] = mk(30 + i);
                end
                8'h31: begin
                    s.num_cycles = 3'd6;
                    for (int i = 0; i < 6; i++) s.cycles[i] = mk(8 + i);
                end
                default: begin s.num_cycles = 3'd1; s.cycles[0] = mk(15); end
            endcase
        end
        return s;
    endfunction

    always_comb schedule_s = decode(opcode_s, cb_prefix_s);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Run the instruction currently in IR. next_byte is presented at its final
    // T3; cond is presented at T3 of M-cycle cond_m (random elsewhere).
    // n_m / fail_m: expected M-cycle count and first fetch-only M-cycle.
    task automatic run_instr(input logic [7:0] next_byte, input logic cond, input int n_m,
                             input int fail_m, input int cond_m, input int abort_k);
        schedule_t   s;
        logic        pre;
        control_t    c;
        logic [30:0] obs;
        s   = decode(cur_op, cur_cb);
        pre = (cur_op == 8'hCB) && !cur_cb;
        for (int k = 0; k < 4 * n_m; k++) begin
            int m = k / 4;
            c = (pre || m >= fail_m) ? FETCH_ONLY_CTRL : s.cycles[m];
            exp_q.push_back({2'(k % 4), 3'(m), cur_op, cur_cb, c, (k == 4 * n_m - 1) && !pre});
        end
        for (int k = 0; k < 4 * n_m; k++) begin
            @(negedge clk);
            data_in_s   = (k == 4 * n_m - 1) ? next_byte : 8'($urandom_range(0, 255));
            cond_true_s = (k % 4 == 3 && k / 4 == cond_m) ? cond : 1'($urandom_range(0, 1));
            obs = {t_cycle_s, m_cycle_s, opcode_s, cb_prefix_s, ctrl_s, instr_done_s};
            check_val($sformatf("op%02h_cb%0d_k%0d", cur_op, cur_cb, k), 64'(obs), 64'(exp_q.pop_front()));
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                obs = {t_cycle_s, m_cycle_s, opcode_s, cb_prefix_s, ctrl_s, instr_done_s};
                check_val("async_reset", 64'(obs), 64'({2'd0, 3'd0, 8'h00, 1'b0, mk(1), 1'b0}));
                exp_q.delete();
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                cur_op = 8'h00;
                cur_cb = 1'b0;
                return;
            end
        end
        cur_cb = pre;
        cur_op = next_byte;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [30:0] obs;
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        data_in_s   = 8'h00;
        cond_true_s = 1'b0;
        cur_op      = 8'h00;
        cur_cb      = 1'b0;
        #12;
        obs = {t_cycle_s, m_cycle_s, opcode_s, cb_prefix_s, ctrl_s, instr_done_s};
        check_val("reset_state", 64'(obs), 64'({2'd0, 3'd0, 8'h00, 1'b0, mk(1), 1'b0}));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // NOP loop, then ADD.
        run_instr(8'h00, 1'b0, 1, 7, -1, -1);
        run_instr(8'h00, 1'b0, 1, 7, -1, -1);
        run_instr(8'h80, 1'b0, 1, 7, -1, -1);
        run_instr(8'h20, 1'b0, 1, 7, -1, -1);
        // Conditional: not taken (2 M), then taken (3 M).
        run_instr(8'h20, 1'b0, 2, 1, 0, -1);
        run_instr(8'hCB, 1'b1, 3, 7, 0, -1);
        // CB prefix then CB 0x37, then CB CB (SET 1,E).
        run_instr(8'h37, 1'b0, 1, 0, -1, -1);
        run_instr(8'hCB, 1'b0, 1, 7, -1, -1);
        run_instr(8'hCB, 1'b0, 1, 0, -1, -1);
        run_instr(8'h10, 1'b0, 2, 7, -1, -1);
        // Illegal num_cycles=0 runs as one M-cycle.
        run_instr(8'hC2, 1'b0, 1, 7, -1, -1);
        // Condition at M1: fail gives 3 M, pass gives 5 M.
        run_instr(8'hC2, 1'b0, 3, 2, 1, -1);
        run_instr(8'h31, 1'b1, 5, 7, 1, -1);
        // Six-cycle schedule, then the same aborted by reset at M2/T1.
        run_instr(8'h31, 1'b0, 6, 7, -1, -1);
        run_instr(8'h80, 1'b0, 6, 7, -1, 9);
        // Implicit NOP after release fetches 0x80.
        run_instr(8'h80, 1'b0, 1, 7, -1, -1);
        run_instr(8'h00, 1'b0, 1, 7, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gb_cpu_sequencer
